// File: rtl/cmd_reg_bank_if.sv
// cmd_reg_bank_if: host register bus plus CMD_master command/response signals.
interface cmd_reg_bank_if;
    logic        wr_en;
    logic        rd_en;
    logic [7:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        new_cmd;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        cmd_busy;
    logic        cmd_complete;
    logic        cmd_complete_en;
    logic        timeout_error;
    logic        timeout_error_en;
    logic [31:0] response_status;
    logic [31:0] response_status_en;
    logic        irq;

    modport slave (
        input  wr_en, rd_en, addr, wr_data, cmd_busy, cmd_complete, cmd_complete_en,
               timeout_error, timeout_error_en, response_status, response_status_en,
        output rd_data, rd_valid, new_cmd, cmd_index, cmd_arg, irq
    );

    modport master (
        output wr_en, rd_en, addr, wr_data, cmd_busy, cmd_complete, cmd_complete_en,
               timeout_error, timeout_error_en, response_status, response_status_en,
        input  rd_data, rd_valid, new_cmd, cmd_index, cmd_arg, irq
    );
endinterface

// File: rtl/cmd_reg_bank.sv
// cmd_reg_bank: SD host register bank and command sequencer feeding CMD_master.
// Define CMD_WATCHDOG_EN to force a timeout after WATCHDOG_CYCLES cycles in WAIT_DONE.
module cmd_reg_bank
`ifdef CMD_WATCHDOG_EN
#(
    parameter int unsigned WATCHDOG_CYCLES = 65535
)
`endif
(
    input logic           CLK_host,
    input logic           reset,
    cmd_reg_bank_if.slave bus
);
    localparam logic [7:0] A_ARG = 8'h08, A_CMD = 8'h0C, A_RSP = 8'h10;
    localparam logic [7:0] A_PST = 8'h24, A_IST = 8'h30, A_IEN = 8'h38;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t      state_q;
    logic [31:0] arg_q, command_q, cmd_arg_q, resp_q, resp_d, rd_data_q, rd_mux;
    logic        st_cc_q, st_cc_d, st_to_q, st_to_d, en_cc_q, en_to_q;
    logic        rd_valid_q, new_cmd_q, irq_q;
    logic        inhibit, wr_arg, wr_cmd, wr_ist, wr_ien, done, hw_to, expire;
    logic [31:0] int_status, present, int_en;

    assign inhibit = state_q != IDLE;
    assign wr_arg  = bus.wr_en && bus.addr == A_ARG;
    assign wr_cmd  = bus.wr_en && bus.addr == A_CMD;
    assign wr_ist  = bus.wr_en && bus.addr == A_IST;
    assign wr_ien  = bus.wr_en && bus.addr == A_IEN;
    assign done    = state_q == WAIT_DONE && bus.cmd_complete_en;
    assign hw_to   = done && bus.timeout_error_en && bus.timeout_error;

`ifdef CMD_WATCHDOG_EN
    localparam int unsigned WDW = $clog2(WATCHDOG_CYCLES + 1);
    logic [WDW-1:0] wd_q;
    // A real completion in the expiry cycle wins over the watchdog.
    assign expire = state_q == WAIT_DONE && !bus.cmd_complete_en && wd_q == WDW'(WATCHDOG_CYCLES - 1);
    always_ff @(posedge CLK_host)
        wd_q <= (reset || state_q != WAIT_DONE) ? '0 : wd_q + 1'b1;
`else
    assign expire = 1'b0;
`endif

    // Bit15 is not stored: it is the read-side image of bit16.
    assign int_status = {15'b0, st_to_q, st_to_q, 14'b0, st_cc_q};
    assign int_en     = {15'b0, en_to_q, 15'b0, en_cc_q};
    assign present    = {30'b0, bus.cmd_busy, inhibit};

    always_comb begin
        st_cc_d = (done && bus.cmd_complete) || (st_cc_q && !(wr_ist && bus.wr_data[0]));
        st_to_d = hw_to || expire || (st_to_q && !(wr_ist && bus.wr_data[16]));
        resp_d  = done ? (resp_q & ~bus.response_status_en) | (bus.response_status & bus.response_status_en) : resp_q;
        rd_mux  = bus.addr == A_ARG ? arg_q :
                  bus.addr == A_CMD ? command_q :
                  bus.addr == A_RSP ? resp_q :
                  bus.addr == A_PST ? present :
                  bus.addr == A_IST ? int_status :
                  bus.addr == A_IEN ? int_en : 32'b0;
    end

    always_ff @(posedge CLK_host) begin
        if (reset) begin
            state_q    <= IDLE;
            arg_q      <= '0;
            command_q  <= '0;
            cmd_arg_q  <= '0;
            resp_q     <= '0;
            rd_data_q  <= '0;
            st_cc_q    <= 1'b0;
            st_to_q    <= 1'b0;
            en_cc_q    <= 1'b0;
            en_to_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            new_cmd_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) rd_data_q <= rd_mux;
            if (wr_arg) arg_q <= bus.wr_data;
            if (wr_ien) begin
                en_cc_q <= bus.wr_data[0];
                en_to_q <= bus.wr_data[16];
            end
            st_cc_q   <= st_cc_d;
            st_to_q   <= st_to_d;
            resp_q    <= resp_d;
            irq_q     <= (st_cc_q && en_cc_q) || (st_to_q && en_to_q);
            new_cmd_q <= 1'b0;
            case (state_q)
                IDLE: if (wr_cmd) begin
                    command_q <= bus.wr_data;
                    cmd_arg_q <= arg_q;
                    new_cmd_q <= 1'b1;
                    state_q   <= ISSUE;
                end
                ISSUE:     state_q <= WAIT_DONE;
                WAIT_DONE: if (done || expire) state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.new_cmd   = new_cmd_q;
    assign bus.cmd_index = command_q[13:8];
    assign bus.cmd_arg   = cmd_arg_q;
    assign bus.irq       = irq_q;
endmodule

// File: tb/tb_cmd_reg_bank.sv
// tb_cmd_reg_bank: self-checking bench for cmd_reg_bank: register table, corner
// sequences, and random transactions against a transaction-level model.
module tb_cmd_reg_bank;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    cmd_reg_bank_if bus();
`ifdef CMD_WATCHDOG_EN
    cmd_reg_bank #(.WATCHDOG_CYCLES(16)) dut (.CLK_host(clk), .reset(rst), .bus(bus));
`else
    cmd_reg_bank dut (.CLK_host(clk), .reset(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rexp;
    } vec_t;

    logic [31:0] m_arg, m_cmd, m_carg, m_resp;
    logic        m_cc, m_to, m_e0, m_e16, m_inh;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.wr_en = 1'b1; bus.addr = a; bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        bus.rd_en = 1'b1; bus.addr = a;
        step();
        bus.rd_en = 1'b0;
        chk("rd_valid", 32'(bus.rd_valid), 32'd1);
        d = bus.rd_data;
    endtask

    task automatic rchk(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(name, d, exp);
    endtask

    task automatic cpl(input logic cc, input logic to, input logic toen, input logic [31:0] rs, input logic [31:0] rsen);
        bus.cmd_complete_en = 1'b1; bus.cmd_complete = cc; bus.timeout_error = to;
        bus.timeout_error_en = toen; bus.response_status = rs; bus.response_status_en = rsen;
        step();
        bus.cmd_complete_en = 1'b0; bus.timeout_error_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        {m_arg, m_cmd, m_carg, m_resp} = '0;
        {m_cc, m_to, m_e0, m_e16, m_inh} = '0;
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] a, input logic busy);
        case (a)
            8'h08:   return m_arg;
            8'h0C:   return m_cmd;
            8'h10:   return m_resp;
            8'h24:   return (m_inh ? 32'h1 : 32'h0) | (busy ? 32'h2 : 32'h0);
            8'h30:   return (m_cc ? 32'h1 : 32'h0) | (m_to ? 32'h0001_8000 : 32'h0);
            8'h38:   return (m_e0 ? 32'h1 : 32'h0) | (m_e16 ? 32'h0001_0000 : 32'h0);
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        vec_t        vt[9];
        logic [7:0]  addrs[8];
        int          op, since;
        logic [7:0]  a;
        logic [31:0] d;
        logic        acc, busy;

        vt[0] = '{8'h08, 32'h1234_5678, 32'h1234_5678};
        vt[1] = '{8'h10, 32'hFFFF_FFFF, 32'h0};
        vt[2] = '{8'h24, 32'hFFFF_FFFF, 32'h0};
        vt[3] = '{8'h38, 32'hFFFF_FFFF, 32'h0001_0001};
        vt[4] = '{8'h30, 32'hFFFF_FFFF, 32'h0};
        vt[5] = '{8'h40, 32'hFFFF_FFFF, 32'h0};
        vt[6] = '{8'h00, 32'hAAAA_AAAA, 32'h0};
        vt[7] = '{8'h38, 32'h0000_0000, 32'h0};
        vt[8] = '{8'h08, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
        addrs = '{8'h08, 8'h0C, 8'h10, 8'h24, 8'h30, 8'h38, 8'h00, 8'hFC};

        bus.wr_en = 0; bus.rd_en = 0; bus.addr = 0; bus.wr_data = 0; bus.cmd_busy = 0;
        bus.cmd_complete = 0; bus.cmd_complete_en = 0; bus.timeout_error = 0;
        bus.timeout_error_en = 0; bus.response_status = 0; bus.response_status_en = 0;
        do_reset();

        chk("rst_rd_data", bus.rd_data, 32'h0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'h0);
        chk("rst_new_cmd", 32'(bus.new_cmd), 32'h0);
        chk("rst_cmd_index", 32'(bus.cmd_index), 32'h0);
        chk("rst_cmd_arg", bus.cmd_arg, 32'h0);
        chk("rst_irq", 32'(bus.irq), 32'h0);

        for (int i = 0; i < 9; i++) begin
            wr(vt[i].addr, vt[i].wdata);
            rchk($sformatf("table[%0d]", i), vt[i].addr, vt[i].rexp);
        end

        // Basic issue
        wr(8'h08, 32'h1234_5678);
        wr(8'h0C, 32'h0000_1100);
        chk("issue_new_cmd", 32'(bus.new_cmd), 32'h1);
        chk("issue_index", 32'(bus.cmd_index), 32'h11);
        chk("issue_arg", bus.cmd_arg, 32'h1234_5678);
        step();
        chk("issue_one_pulse", 32'(bus.new_cmd), 32'h0);
        rchk("present_busy0", 8'h24, 32'h1);
        bus.cmd_busy = 1'b1;
        rchk("present_busy1", 8'h24, 32'h3);
        bus.cmd_busy = 1'b0;

        // Inhibit
        wr(8'h0C, 32'h0000_0500);
        chk("inhibit_no_cmd", 32'(bus.new_cmd), 32'h0);
        chk("inhibit_index", 32'(bus.cmd_index), 32'h11);
        rchk("inhibit_cmd_reg", 8'h0C, 32'h0000_1100);

        // Completion and irq latency
        wr(8'h38, 32'h1);
        cpl(1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        chk("irq_not_yet", 32'(bus.irq), 32'h0);
        step();
        chk("irq_set", 32'(bus.irq), 32'h1);
        rchk("resp", 8'h10, 32'hDEAD_BEEF);
        rchk("int_cc", 8'h30, 32'h1);
        rchk("present_done", 8'h24, 32'h0);
        wr(8'h30, 32'h1);
        step();
        chk("irq_clear", 32'(bus.irq), 32'h0);
        rchk("int_w1c", 8'h30, 32'h0);

        // Timeout plus partial response capture
        wr(8'h0C, 32'h0000_1500);
        step();
        cpl(1'b0, 1'b1, 1'b1, 32'h0000_FFFF, 32'h0000_00FF);
        rchk("resp_partial", 8'h10, 32'hDEAD_BEFF);
        rchk("int_to", 8'h30, 32'h0001_8000);
        wr(8'h30, 32'h0001_0000);
        rchk("int_to_w1c", 8'h30, 32'h0);

        // Completion ignored in IDLE and ISSUE
        cpl(1'b1, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF);
        rchk("idle_cpl_ignored", 8'h30, 32'h0);
        wr(8'h0C, 32'h0000_0200);
        cpl(1'b1, 1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF);
        rchk("issue_cpl_ignored", 8'h24, 32'h1);
        cpl(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rchk("plain_cpl_int", 8'h30, 32'h0);
        rchk("plain_cpl_present", 8'h24, 32'h0);

        // Completion coincident with COMMAND write
        wr(8'h0C, 32'h0000_0300);
        step();
        bus.wr_en = 1'b1; bus.addr = 8'h0C; bus.wr_data = 32'h0000_0700;
        cpl(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.wr_en = 1'b0;
        chk("coinc_no_cmd", 32'(bus.new_cmd), 32'h0);
        chk("coinc_index", 32'(bus.cmd_index), 32'h3);
        rchk("coinc_int", 8'h30, 32'h1);

        // W1C racing a hardware set of bit0
        wr(8'h0C, 32'h0000_0400);
        step();
        bus.wr_en = 1'b1; bus.addr = 8'h30; bus.wr_data = 32'h1;
        cpl(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.wr_en = 1'b0;
        rchk("race_set_wins", 8'h30, 32'h1);

        // Reset mid-command with a coincident completion
        wr(8'h08, 32'h5555_0000);
        wr(8'h0C, 32'h0000_2A00);
        step();
        rst = 1'b1;
        cpl(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rst = 1'b0;
        chk("mid_rst_new_cmd", 32'(bus.new_cmd), 32'h0);
        chk("mid_rst_index", 32'(bus.cmd_index), 32'h0);
        chk("mid_rst_arg", bus.cmd_arg, 32'h0);
        chk("mid_rst_irq", 32'(bus.irq), 32'h0);
        rchk("mid_rst_int", 8'h30, 32'h0);
        rchk("mid_rst_resp", 8'h10, 32'h0);
        wr(8'h0C, 32'h0000_0900);
        chk("post_rst_issue", 32'(bus.new_cmd), 32'h1);
        chk("post_rst_index", 32'(bus.cmd_index), 32'h9);
        step();
        cpl(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

`ifdef CMD_WATCHDOG_EN
        // Watchdog: ISSUE then 16 WAIT_DONE cycles, expiry visible after that
        wr(8'h0C, 32'h0000_0100);
        repeat (16) step();
        rchk("wd_still_busy", 8'h24, 32'h1);
        rchk("wd_int", 8'h30, 32'h0001_8000);
        rchk("wd_present", 8'h24, 32'h0);
        rchk("wd_resp", 8'h10, 32'h0);
`endif

        // Random transactions against the model
        do_reset();
        since = 0;
        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(0, 4));
            if (m_inh && since >= 3) op = 2;
            a = addrs[$urandom_range(0, 7)];
            d = $urandom;
            if (op == 0) begin
                wr(a, d);
                case (a)
                    8'h08: m_arg = d;
                    8'h0C: begin
                        acc = !m_inh;
                        if (acc) begin
                            m_cmd = d; m_carg = m_arg; m_inh = 1'b1; since = 0;
                        end
                        chk("rnd_new_cmd", 32'(bus.new_cmd), 32'(acc));
                        chk("rnd_index", 32'(bus.cmd_index), 32'(m_cmd[13:8]));
                        chk("rnd_arg", bus.cmd_arg, m_carg);
                    end
                    8'h30: begin
                        if (d[0]) m_cc = 1'b0;
                        if (d[16]) m_to = 1'b0;
                    end
                    8'h38: begin
                        m_e0 = d[0]; m_e16 = d[16];
                    end
                    default: ;
                endcase
            end else if (op == 1) begin
                busy = 1'($urandom);
                bus.cmd_busy = busy;
                rchk("rnd_read", a, m_read(a, busy));
                bus.cmd_busy = 1'b0;
            end else if (op == 2) begin
                logic cc, to, toen;
                logic [31:0] rs, rsen;
                cc = 1'($urandom); to = 1'($urandom); toen = 1'($urandom);
                rs = $urandom; rsen = $urandom;
                if (m_inh) step();
                cpl(cc, to, toen, rs, rsen);
                if (m_inh) begin
                    m_resp = (m_resp & ~rsen) | (rs & rsen);
                    if (cc) m_cc = 1'b1;
                    if (to && toen) m_to = 1'b1;
                    m_inh = 1'b0;
                end
            end else if (op == 3) begin
                step();
                step();
                chk("rnd_irq", 32'(bus.irq), 32'((m_cc && m_e0) || (m_to && m_e16)));
            end else begin
                step();
            end
            if (m_inh) since++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
